i2c_cfg_sequencer: RTL and testbench

Sequencer that drives `i2c_master` through a fixed table of I2C register writes, one transaction per entry: START, address+W, register, data, STOP. Used at power-up or on request to configure an I2C peripheral without CPU involvement. Owns the master's `tick` generation, handles NACK with bounded retries, and reports completion or the failing entry.

---
 rtl/i2c_cfg_pkg.sv | 36 +++
 rtl/i2c_cfg_sequencer_if.sv | 26 ++
 rtl/i2c_cfg_sequencer_tick.sv | 23 ++
 rtl/i2c_cfg_sequencer.sv | 157 +++++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_cfg_pkg.sv
// Shared types and table-word layout for the I2C configuration sequencer.
// The table word is {dev[6:0], reg[7:0], data[7:0]}.
package i2c_cfg_pkg;

  localparam int TBL_W   = 23;
  localparam int DEV_HI  = 22;
  localparam int DEV_LO  = 16;
  localparam int REG_HI  = 15;
  localparam int REG_LO  = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADDR,
    S_REG,
    S_DATA,
    S_STOP,
    S_GAP,
    S_FIN
  } seq_state_t;

  function automatic logic [6:0] tbl_dev(input logic [TBL_W-1:0] w);
    return w[DEV_HI:DEV_LO];
  endfunction

  function automatic logic [7:0] tbl_reg(input logic [TBL_W-1:0] w);
    return w[REG_HI:REG_LO];
  endfunction

  function automatic logic [7:0] tbl_dat(input logic [TBL_W-1:0] w);
    return w[DATA_HI:DATA_LO];
  endfunction

endpackage

// File: rtl/i2c_cfg_sequencer_if.sv
// Command/status bus between the sequencer and the byte-level i2c_master.
// The sequencer side is "master"; the I2C engine side is "slave".
interface i2c_cfg_sequencer_if;

  logic       tick;
  logic       m_start;
  logic       m_stop;
  logic       m_write;
  logic       m_read;
  logic       m_ack_in;
  logic [7:0] m_data_in;
  logic       m_done;
  logic       m_busy;
  logic       m_ack_err;

  modport master (
    output tick, m_start, m_stop, m_write, m_read, m_ack_in, m_data_in,
    input  m_done, m_busy, m_ack_err
  );

  modport slave (
    input  tick, m_start, m_stop, m_write, m_read, m_ack_in, m_data_in,
    output m_done, m_busy, m_ack_err
  );

endinterface

// File: rtl/i2c_cfg_sequencer_tick.sv
// Free-running divider: one-clk tick every TICK_DIV clocks (counter 0..TICK_DIV-1).
module i2c_tick_gen #(
  parameter int TICK_DIV = 250
)(
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else r_cnt <= r_cnt + CW'(1);
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks a register-write table through i2c_master: START, addr+W, reg, data, STOP
// per entry, retrying NACKed entries up to MAX_RETRY extra times.
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int TICK_DIV  = 250,
  parameter int N_ENTRIES = 16,
  parameter int AW        = 4,
  parameter int MAX_RETRY = 3,
  parameter int GAP_TICKS = 8
)(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  output logic             seq_busy,
  output logic             seq_done,
  output logic             seq_err,
  output logic [AW-1:0]    err_idx,
  output logic [AW-1:0]    tbl_addr,
  input  logic [TBL_W-1:0] tbl_data,
  i2c_cfg_sequencer_if.master mst
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  seq_state_t    r_state;
  logic [AW-1:0] r_idx;
  logic [RW-1:0] r_retry;
  logic [GW-1:0] r_gap;
  logic [7:0]    r_reg;
  logic [7:0]    r_dat;
  logic          r_nack;
  logic          w_tick;
  logic          w_last;
  logic          w_retry_left;

  i2c_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  assign mst.tick     = w_tick;
  assign mst.m_read   = 1'b0;
  assign tbl_addr     = r_idx;
  assign w_last       = (r_idx == AW'(N_ENTRIES - 1));
  assign w_retry_left = (r_retry != RW'(MAX_RETRY));

  // Every m_* change below lands the clk after m_done, well ahead of the
  // master's next tick, so m_stop / next byte overrides its auto-continue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_retry       <= '0;
      r_gap         <= '0;
      r_reg         <= '0;
      r_dat         <= '0;
      r_nack        <= 1'b0;
      seq_busy      <= 1'b0;
      seq_done      <= 1'b0;
      seq_err       <= 1'b0;
      err_idx       <= '0;
      mst.m_start   <= 1'b0;
      mst.m_stop    <= 1'b0;
      mst.m_write   <= 1'b0;
      mst.m_ack_in  <= 1'b1;
      mst.m_data_in <= '0;
    end else begin
      seq_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            seq_err  <= 1'b0;
            r_idx    <= '0;
            r_retry  <= '0;
            seq_busy <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_reg         <= tbl_reg(tbl_data);
          r_dat         <= tbl_dat(tbl_data);
          r_nack        <= 1'b0;
          mst.m_start   <= 1'b1;
          mst.m_write   <= 1'b1;
          mst.m_data_in <= {tbl_dev(tbl_data), 1'b0};
          r_state       <= S_ADDR;
        end
        S_ADDR: begin
          if (mst.m_done) begin
            mst.m_start <= 1'b0;
            if (mst.m_ack_err) begin
              r_nack     <= 1'b1;
              mst.m_stop <= 1'b1;
              r_state    <= S_STOP;
            end else begin
              mst.m_data_in <= r_reg;
              r_state       <= S_REG;
            end
          end
        end
        S_REG: begin
          if (mst.m_done) begin
            if (mst.m_ack_err) begin
              r_nack     <= 1'b1;
              mst.m_stop <= 1'b1;
              r_state    <= S_STOP;
            end else begin
              mst.m_data_in <= r_dat;
              r_state       <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (mst.m_done) begin
            r_nack     <= mst.m_ack_err;
            mst.m_stop <= 1'b1;
            r_state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (mst.m_done) begin
            mst.m_stop  <= 1'b0;
            mst.m_write <= 1'b0;
            if (r_nack && w_retry_left) begin
              r_retry <= r_retry + RW'(1);
              r_gap   <= '0;
              r_state <= S_GAP;
            end else if (r_nack || w_last) begin
              seq_err  <= r_nack;
              if (r_nack) err_idx <= r_idx;
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
              r_state  <= S_FIN;
            end else begin
              r_idx   <= r_idx + AW'(1);
              r_retry <= '0;
              r_gap   <= '0;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap == GW'(GAP_TICKS)) r_state <= S_LOAD;
          else if (w_tick) r_gap <= r_gap + GW'(1);
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench: transaction-level i2c_master/slave model plus a table-driven model of
// the expected byte stream, NACK retries and error reporting.
module tb_i2c_cfg_sequencer;
  import i2c_cfg_pkg::*;

  localparam int TD = 4, N = 3, AW = 4, MR = 3, GT = 3;
  localparam int BYTE_T = 9, STOP_T = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             go = 1'b0;
  logic             seq_busy, seq_done, seq_err;
  logic [AW-1:0]    err_idx, tbl_addr;
  logic [TBL_W-1:0] tbl_data;
  logic [TBL_W-1:0] tbl [16];

  int nk [N][MR+1];      // per entry/attempt: -1 ack all, 0/1/2 NACK addr/reg/data
  int checks = 0, errors = 0;
  logic [8:0] got[$];    // bytes seen on the bus; 9'h100 marks STOP
  logic [8:0] expq[$];
  int plan[$];
  int txn, txn_base = 0;
  int ms, cnt, pos;
  bit exp_err;
  int exp_eidx;

  i2c_cfg_sequencer_if bus();

  i2c_cfg_sequencer #(
    .TICK_DIV(TD), .N_ENTRIES(N), .AW(AW), .MAX_RETRY(MR), .GAP_TICKS(GT)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .go(go),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err),
    .err_idx(err_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .mst(bus)
  );

  always #5 clk = ~clk;
  assign tbl_data   = tbl[tbl_addr];
  assign bus.m_busy = (ms != 0);

  // Master + slave: 0 idle, 1 shifting byte, 2 byte done/decide, 3 STOP.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms <= 0; cnt <= 0; pos <= 0; txn <= 0;
      bus.m_done <= 1'b0; bus.m_ack_err <= 1'b0;
    end else begin
      bus.m_done <= 1'b0;
      if (bus.tick) begin
        case (ms)
          0: if (bus.m_start && bus.m_write) begin
               got.push_back({1'b0, bus.m_data_in});
               pos <= 0; cnt <= BYTE_T; ms <= 1;
             end
          1: if (cnt > 1) cnt <= cnt - 1;
             else begin
               bus.m_done    <= 1'b1;
               bus.m_ack_err <= ((txn - txn_base) < plan.size()) ?
                                (plan[txn - txn_base] == pos) : 1'b0;
               ms <= 2;
             end
          2: if (bus.m_stop) begin
               got.push_back(9'h100); cnt <= STOP_T; ms <= 3;
             end else if (bus.m_write) begin
               got.push_back({1'b0, bus.m_data_in});
               pos <= pos + 1; cnt <= BYTE_T; ms <= 1;
             end else ms <= 0;
          default: if (cnt > 1) cnt <= cnt - 1;
             else begin
               bus.m_done <= 1'b1; bus.m_ack_err <= 1'b0;
               txn <= txn + 1; ms <= 0;
             end
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic void clear_nk();
    for (int e = 0; e < N; e++)
      for (int a = 0; a <= MR; a++) nk[e][a] = -1;
  endfunction

  function automatic void rand_tbl();
    for (int e = 0; e < N; e++) tbl[e] = TBL_W'($urandom);
  endfunction

  // Expected bus traffic: each attempt sends addr, then bytes up to the NACKed
  // one, then STOP; an entry advances on a clean attempt, aborts after MR retries.
  function automatic void build();
    expq.delete(); plan.delete(); exp_err = 1'b0; exp_eidx = 0;
    for (int e = 0; e < N; e++) begin
      for (int a = 0; a <= MR; a++) begin
        int s = nk[e][a];
        logic [TBL_W-1:0] w = tbl[e];
        expq.push_back({1'b0, w[22:16], 1'b0});
        if (s < 0 || s >= 1) expq.push_back({1'b0, w[15:8]});
        if (s < 0 || s >= 2) expq.push_back({1'b0, w[7:0]});
        expq.push_back(9'h100);
        plan.push_back(s);
        if (s < 0) break;
        if (a == MR) begin exp_err = 1'b1; exp_eidx = e; return; end
      end
    end
  endfunction

  task automatic do_run(input string tag, input bit hold_go);
    int gb, nd, cyc;
    bit seen;
    logic [TBL_W-1:0] w0;
    build();
    w0 = tbl[0];
    gb = got.size(); txn_base = txn; nd = 0; seen = 1'b0; cyc = 0;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1;
    chk({tag, ":busy_1clk"}, seq_busy, 1);
    chk({tag, ":err_cleared"}, seq_err, 0);
    chk({tag, ":tbl_addr0"}, tbl_addr, 0);
    chk({tag, ":start_not_yet"}, bus.m_start, 0);
    if (!hold_go) go = 1'b0;
    @(posedge clk); #1;
    chk({tag, ":start_2clk"}, bus.m_start, 1);
    chk({tag, ":addr_byte"}, bus.m_data_in, {w0[22:16], 1'b0});
    while (!seen && cyc < 20000) begin
      @(negedge clk); cyc++;
      if (hold_go && (got.size() - gb) >= 2) go = 1'b0;
      if (seq_done) begin seen = 1'b1; nd++; end
    end
    go = 1'b0;
    chk({tag, ":done_seen"}, seen, 1);
    repeat (40) begin @(negedge clk); if (seq_done) nd++; end
    chk({tag, ":done_pulses"}, nd, 1);
    chk({tag, ":busy_low"}, seq_busy, 0);
    chk({tag, ":seq_err"}, seq_err, exp_err);
    if (exp_err) chk({tag, ":err_idx"}, err_idx, exp_eidx);
    chk({tag, ":stream_len"}, got.size() - gb, expq.size());
    for (int i = 0; i < expq.size() && gb + i < got.size(); i++)
      chk($sformatf("%s:byte%0d", tag, i), got[gb + i], expq[i]);
  endtask

  initial begin
    int last, nt, gb, cyc;
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    clear_nk();

    #1 reset_n = 1'b0;
    #1;
    chk("rst:busy", seq_busy, 0);
    chk("rst:done", seq_done, 0);
    chk("rst:err", seq_err, 0);
    chk("rst:ack_in", bus.m_ack_in, 1);
    chk("rst:start", bus.m_start, 0);
    chk("rst:read", bus.m_read, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    last = -1; nt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.tick) begin
        if (last >= 0) chk("tick:spacing", i - last, TD);
        last = i; nt++;
      end
    end
    chk("tick:count", nt, 40 / TD);

    tbl[0] = {7'h3C, 8'h10, 8'hA5};
    tbl[1] = {7'h3C, 8'h11, 8'h5A};
    tbl[2] = TBL_W'($urandom);
    do_run("clean", 1'b0);

    nk[0][0] = 0;
    do_run("addr_nack_once", 1'b0);
    clear_nk();

    rand_tbl();
    for (int a = 0; a <= MR; a++) nk[1][a] = 2;
    do_run("data_nack_persist", 1'b0);
    clear_nk();

    rand_tbl();
    do_run("go_held", 1'b1);
    do_run("go_pulse", 1'b0);

    for (int r = 0; r < 4; r++) begin
      rand_tbl();
      for (int e = 0; e < N; e++)
        for (int a = 0; a <= MR; a++)
          nk[e][a] = ($urandom_range(3) == 0) ? int'($urandom_range(2)) : -1;
      do_run($sformatf("rand%0d", r), 1'b0);
    end
    clear_nk();

    // Reset while entry 0's data byte is on the bus.
    rand_tbl();
    build();
    gb = got.size(); txn_base = txn; cyc = 0;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    while ((got.size() - gb) < 3 && cyc < 5000) begin @(negedge clk); cyc++; end
    chk("rst_mid:reached_data", (got.size() - gb) >= 3, 1);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid:busy", seq_busy, 0);
    chk("rst_mid:stop", bus.m_stop, 0);
    chk("rst_mid:write", bus.m_write, 0);
    chk("rst_mid:data_in", bus.m_data_in, 0);
    chk("rst_mid:tbl_addr", tbl_addr, 0);
    chk("rst_mid:ack_in", bus.m_ack_in, 1);
    chk("rst_mid:tick", bus.tick, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    do_run("after_reset", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
